// File: rtl/spi_pkg.sv
// Shared types and constants for the contactor sequencer: FSM state encoding,
// feedback codes and the default contactor count.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_FAULT = 3'd4
  } seq_state_t;

  localparam logic [1:0] FB_OPEN   = 2'b01;
  localparam logic [1:0] FB_CLOSED = 2'b10;

  localparam int N_CONTACTORS_DEFAULT = 21;

  // Index width is fixed by the 5-bit active_idx output, so up to 32 contactors.
  localparam int IDX_W = 5;

endpackage

// File: rtl/contactor_rr_picker.sv
// Combinational round-robin finder: lowest set bit of pending at or above ptr,
// wrapping from N-1 back to 0.
module contactor_rr_picker
  import spi_pkg::*;
#(
  parameter int N = N_CONTACTORS_DEFAULT
) (
  input  logic [N-1:0]     pending,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W:0] w_cand;

  // Walk offsets 0..N-1 from ptr; the first hit wins, later hits are ignored.
  always_comb begin
    idx    = '0;
    found  = 1'b0;
    w_cand = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(N)) begin
        w_cand = w_cand - (IDX_W+1)'(N);
      end
      if (!found && pending[w_cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = w_cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/contactor_sequencer.sv
// Changes one contactor at a time toward spi_requests, waits for router feedback
// to confirm each change, and enforces an idle gap between successive changes.
module contactor_sequencer
  import spi_pkg::*;
#(
  parameter int N_CONTACTORS   = N_CONTACTORS_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int GAP_CYCLES     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CONTACTORS-1:0]   spi_requests,
  input  logic [2*N_CONTACTORS-1:0] router_feedback,
  input  logic                      emergency_off,
  input  logic                      clear_errors,
  output logic [N_CONTACTORS-1:0]   contactor_cmd,
  output logic                      busy,
  output logic [4:0]                active_idx,
  output logic                      feedback_timeout_error,
  output logic                      invalid_feedback
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  seq_state_t              r_state;
  logic [N_CONTACTORS-1:0] r_cmd;
  logic [IDX_W-1:0]        r_ptr;
  logic [IDX_W-1:0]        r_active_idx;
  logic [TW-1:0]           r_timer;
  logic [GW-1:0]           r_gap;
  logic                    r_timeout_err;
  logic                    r_invalid_fb;

  logic [N_CONTACTORS-1:0] w_pending;
  logic [IDX_W-1:0]        w_pick_idx;
  logic                    w_found;
  logic [1:0]              w_fb;
  logic [1:0]              w_fb_expected;
  logic                    w_fb_invalid;
  logic                    w_fb_match;
  logic                    w_timer_done;
  logic                    w_gap_done;
  logic [IDX_W-1:0]        w_next_ptr;

  assign w_pending = spi_requests ^ r_cmd;

  contactor_rr_picker #(
    .N (N_CONTACTORS)
  ) u_picker (
    .pending (w_pending),
    .ptr     (r_ptr),
    .idx     (w_pick_idx),
    .found   (w_found)
  );

  assign w_fb          = router_feedback[{r_active_idx, 1'b0} +: 2];
  assign w_fb_expected = r_cmd[r_active_idx] ? FB_CLOSED : FB_OPEN;
  assign w_fb_invalid  = (w_fb == 2'b00) || (w_fb == 2'b11);
  assign w_fb_match    = (w_fb == w_fb_expected);
  assign w_timer_done  = (r_timer == TW'(TIMEOUT_CYCLES - 1));
  assign w_gap_done    = (r_gap == GW'(GAP_CYCLES - 1));
  assign w_next_ptr    = (r_active_idx == IDX_W'(N_CONTACTORS - 1)) ? '0 : r_active_idx + 1'b1;

  // Emergency-off overrides everything except FAULT, where the drive is already
  // zero and only an explicit clear may leave the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cmd         <= '0;
      r_ptr         <= '0;
      r_active_idx  <= '0;
      r_timer       <= '0;
      r_gap         <= '0;
      r_timeout_err <= 1'b0;
      r_invalid_fb  <= 1'b0;
    end else if (r_state != ST_FAULT && emergency_off) begin
      r_cmd   <= '0;
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_active_idx <= w_pick_idx;
            r_state      <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          r_cmd[r_active_idx] <= ~r_cmd[r_active_idx];
          r_timer             <= '0;
          r_state             <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_fb_invalid) begin
            r_invalid_fb <= 1'b1;
            r_cmd        <= '0;
            r_state      <= ST_FAULT;
          end else if (w_fb_match) begin
            r_gap   <= '0;
            r_state <= ST_GAP;
          end else if (w_timer_done) begin
            r_timeout_err <= 1'b1;
            r_cmd         <= '0;
            r_state       <= ST_FAULT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_GAP: begin
          if (w_gap_done) begin
            r_ptr   <= w_next_ptr;
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        ST_FAULT: begin
          if (clear_errors && !emergency_off) begin
            r_timeout_err <= 1'b0;
            r_invalid_fb  <= 1'b0;
            r_state       <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign contactor_cmd          = r_cmd;
  assign busy                   = (r_state != ST_IDLE);
  assign active_idx             = r_active_idx;
  assign feedback_timeout_error = r_timeout_err;
  assign invalid_feedback       = r_invalid_fb;

endmodule

// File: tb/tb_contactor_sequencer.sv
// Directed self-checking bench for contactor_sequencer: single change, round-robin
// order, timeout, emergency-off, invalid feedback and asynchronous reset.
module tb_contactor_sequencer;
  import spi_pkg::*;

  localparam int N = 21;

  logic          clk;
  logic          rst;
  logic [N-1:0]  spiRequests;
  logic [2*N-1:0] routerFeedback;
  logic          emergencyOff;
  logic          clearErrors;
  logic [N-1:0]  contactorCmd;
  logic          busy;
  logic [4:0]    activeIdx;
  logic          timeoutErr;
  logic          invalidFb;

  int passCount;
  int checkCount;

  contactor_sequencer #(
    .N_CONTACTORS   (N),
    .TIMEOUT_CYCLES (1000),
    .GAP_CYCLES     (16)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .spi_requests           (spiRequests),
    .router_feedback        (routerFeedback),
    .emergency_off          (emergencyOff),
    .clear_errors           (clearErrors),
    .contactor_cmd          (contactorCmd),
    .busy                   (busy),
    .active_idx             (activeIdx),
    .feedback_timeout_error (timeoutErr),
    .invalid_feedback       (invalidFb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tickCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] req, input logic emerg, input logic clr);
    spiRequests  = req;
    emergencyOff = emerg;
    clearErrors  = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    tickCycles(1);
    rst = 1'b0;
  endtask

  // One full change: APPLY, WAIT (extraWait unmatched cycles), GAP of 16, IDLE.
  task automatic serviceOne(input int idx, input logic [N-1:0] cmdAfter, input int extraWait, input string tag);
    routerFeedback[2*idx +: 2] = cmdAfter[idx] ? FB_OPEN : FB_CLOSED;
    tickCycles(1);
    checkOutput({tag, "_idx"}, 32'(activeIdx), 32'(idx));
    checkOutput({tag, "_busyApply"}, 32'(busy), 32'd1);
    tickCycles(1);
    checkOutput({tag, "_cmd"}, 32'(contactorCmd), 32'(cmdAfter));
    if (extraWait > 0) begin
      tickCycles(extraWait);
      checkOutput({tag, "_busyWait"}, 32'(busy), 32'd1);
    end
    routerFeedback[2*idx +: 2] = cmdAfter[idx] ? FB_CLOSED : FB_OPEN;
    tickCycles(1);
    checkOutput({tag, "_busyGapStart"}, 32'(busy), 32'd1);
    tickCycles(15);
    checkOutput({tag, "_busyGapEnd"}, 32'(busy), 32'd1);
    tickCycles(1);
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    checkOutput({tag, "_errs"}, 32'({timeoutErr, invalidFb}), 32'd0);
  endtask

  initial begin
    passCount      = 0;
    checkCount     = 0;
    rst            = 1'b1;
    routerFeedback = {N{FB_OPEN}};
    applyStimulus('0, 1'b0, 1'b0);
    tickCycles(2);
    checkOutput("rst_cmd", 32'(contactorCmd), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_idx", 32'(activeIdx), 32'd0);
    checkOutput("rst_errs", 32'({timeoutErr, invalidFb}), 32'd0);
    rst = 1'b0;

    // Single close of contactor 3, feedback arriving two cycles after APPLY.
    applyStimulus(21'(1 << 3), 1'b0, 1'b0);
    serviceOne(3, 21'(1 << 3), 1, "c3close");
    tickCycles(2);
    checkOutput("c3_staysIdle", 32'(busy), 32'd0);

    // Round robin from ptr=1: contactor 2 before contactor 0.
    resetDut();
    routerFeedback = {N{FB_OPEN}};
    applyStimulus(21'h1, 1'b0, 1'b0);
    serviceOne(0, 21'h1, 0, "c0close");
    applyStimulus(21'h0, 1'b0, 1'b0);
    serviceOne(0, 21'h0, 0, "c0open");
    applyStimulus(21'h5, 1'b0, 1'b0);
    serviceOne(2, 21'h4, 0, "rr_c2");
    serviceOne(0, 21'h5, 0, "rr_c0");

    // Timeout on contactor 7 with feedback stuck open.
    applyStimulus(21'h85, 1'b0, 1'b0);
    routerFeedback[14 +: 2] = FB_OPEN;
    tickCycles(1);
    checkOutput("to_idx", 32'(activeIdx), 32'd7);
    tickCycles(1);
    checkOutput("to_cmdWait", 32'(contactorCmd), 32'h85);
    tickCycles(999);
    checkOutput("to_noErrYet", 32'(timeoutErr), 32'd0);
    checkOutput("to_cmdStill", 32'(contactorCmd), 32'h85);
    tickCycles(1);
    checkOutput("to_flag", 32'(timeoutErr), 32'd1);
    checkOutput("to_cmdCleared", 32'(contactorCmd), 32'd0);
    checkOutput("to_faultBusy", 32'(busy), 32'd1);
    applyStimulus(21'h0, 1'b0, 1'b0);
    tickCycles(3);
    checkOutput("to_faultHolds", 32'(busy), 32'd1);
    applyStimulus(21'h0, 1'b0, 1'b1);
    tickCycles(1);
    applyStimulus(21'h0, 1'b0, 1'b0);
    checkOutput("to_clearIdle", 32'(busy), 32'd0);
    checkOutput("to_clearFlags", 32'({timeoutErr, invalidFb}), 32'd0);

    // Close three contactors (ptr=1), then emergency-off during a fourth WAIT.
    applyStimulus(21'h7, 1'b0, 1'b0);
    serviceOne(1, 21'h2, 0, "em_c1");
    serviceOne(2, 21'h6, 0, "em_c2");
    serviceOne(0, 21'h7, 0, "em_c0");
    applyStimulus(21'h27, 1'b0, 1'b0);
    routerFeedback[10 +: 2] = FB_OPEN;
    tickCycles(1);
    checkOutput("em_idx5", 32'(activeIdx), 32'd5);
    tickCycles(1);
    checkOutput("em_cmdWait", 32'(contactorCmd), 32'h27);
    applyStimulus(21'h27, 1'b1, 1'b0);
    tickCycles(1);
    checkOutput("em_cmdOff", 32'(contactorCmd), 32'd0);
    checkOutput("em_idle", 32'(busy), 32'd0);
    tickCycles(3);
    checkOutput("em_noApply", 32'(busy), 32'd0);
    checkOutput("em_cmdStillOff", 32'(contactorCmd), 32'd0);
    applyStimulus(21'h27, 1'b0, 1'b0);
    tickCycles(1);
    checkOutput("em_resumeBusy", 32'(busy), 32'd1);
    checkOutput("em_resumeIdx", 32'(activeIdx), 32'd1);

    // Invalid feedback on contactor 12; clear is ignored while emergency is high.
    resetDut();
    routerFeedback = {N{FB_OPEN}};
    applyStimulus(21'(1 << 12), 1'b0, 1'b0);
    tickCycles(1);
    checkOutput("inv_idx", 32'(activeIdx), 32'd12);
    tickCycles(1);
    checkOutput("inv_cmd", 32'(contactorCmd), 32'(1 << 12));
    routerFeedback[24 +: 2] = 2'b11;
    tickCycles(1);
    checkOutput("inv_flag", 32'(invalidFb), 32'd1);
    checkOutput("inv_noTimeout", 32'(timeoutErr), 32'd0);
    checkOutput("inv_cmdCleared", 32'(contactorCmd), 32'd0);
    checkOutput("inv_fault", 32'(busy), 32'd1);
    applyStimulus('0, 1'b1, 1'b1);
    tickCycles(1);
    applyStimulus('0, 1'b1, 1'b0);
    tickCycles(1);
    checkOutput("inv_clearBlocked", 32'(busy), 32'd1);
    checkOutput("inv_flagHeld", 32'(invalidFb), 32'd1);
    applyStimulus('0, 1'b0, 1'b1);
    tickCycles(1);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("inv_clearIdle", 32'(busy), 32'd0);
    checkOutput("inv_flagCleared", 32'(invalidFb), 32'd0);

    // Asynchronous reset in the middle of GAP.
    routerFeedback[24 +: 2] = FB_OPEN;
    applyStimulus(21'(1 << 12), 1'b0, 1'b0);
    tickCycles(2);
    routerFeedback[24 +: 2] = FB_CLOSED;
    tickCycles(1);
    tickCycles(5);
    checkOutput("ar_gapBusy", 32'(busy), 32'd1);
    checkOutput("ar_gapCmd", 32'(contactorCmd), 32'(1 << 12));
    applyStimulus('0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    checkOutput("ar_cmd", 32'(contactorCmd), 32'd0);
    checkOutput("ar_busy", 32'(busy), 32'd0);
    checkOutput("ar_idx", 32'(activeIdx), 32'd0);
    checkOutput("ar_errs", 32'({timeoutErr, invalidFb}), 32'd0);
    tickCycles(1);
    rst = 1'b0;
    tickCycles(2);
    checkOutput("ar_staysIdle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
